pipeline_hazard_ctrl: RTL and testbench
=======================================

// Module: pipeline_hazard_ctrl
// PURPOSE
//  Central stall/flush sequencer for the 5-stage 16-bit pipeline.
//  Drives WriteEnable and bubble-injection (flush) controls of PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
//  Sources: load-use hazards, I/D memory miss stalls, taken branches resolved in ID, and halt retirement.
//  Sits beside the pipeline registers; purely control, carries no datapath.
// PARAMETERS
//  REG_W  4   register-index width
//  CNT_W  16  width of performance counters (PERF_CNT_EN only)
// PORTS
//  clk              in   1      clock, rising edge
//  rst              in   1      asynchronous active-low reset
//  ID_SrcReg1       in   REG_W  source reg 1 of instruction in ID
//  ID_SrcReg2       in   REG_W  source reg 2 of instruction in ID
//  ID_Uses1         in   1      ID instruction reads ID_SrcReg1
//  ID_Uses2         in   1      ID instruction reads ID_SrcReg2
//  ID_BranchTaken   in   1      branch in ID resolved taken
//  EX_MemRead       in   1      instruction in EX is a load
//  EX_WReg          in   REG_W  destination reg of EX instruction
//  EXMEM_Halt       in   1      halt flag at EX/MEM output
//  IMem_Stall       in   1      instruction memory miss in progress
//  DMem_Stall       in   1      data memory miss in progress
//  PC_WriteEnable   out  1      PC update
//  IFID_WriteEnable out  1      IF/ID load
//  IDEX_WriteEnable out  1      ID/EX load
//  EXMEM_WriteEnable out 1      EX/MEM load
//  MEMWB_WriteEnable out 1      MEM/WB load
//  IFID_Flush       out  1      load bubble into IF/ID
//  IDEX_Flush       out  1      load bubble into ID/EX
//  EXMEM_Flush      out  1      load bubble into EX/MEM
//  MEMWB_Flush      out  1      load bubble into MEM/WB
//  Halted           out  1      processor halted
// BEHAVIOUR
//  Outputs are combinational from state and inputs, same-cycle; no added latency.
//  Flush is meaningful only with the matching WriteEnable=1.
//  While rst=0: every output 0, state=RUN.
//  RUN is the only state after reset release.
//  States:
//   RUN      normal issue
//   DSTALL   data miss
//   HALTING  drain halt to WB
//   HALTED   terminal; left only by reset
//  Hazard definition:
//   loaduse = EX_MemRead & EX_WReg!=0 & ((ID_Uses1 & ID_SrcReg1==EX_WReg) | (ID_Uses2 & ID_SrcReg2==EX_WReg)).
//  RUN priority, highest first; enables default 1 and flushes default 0:
//   1. DMem_Stall: PC/IFID/IDEX/EXMEM WE=0; MEMWB WE=1 with Flush=1. Next state DSTALL.
//   2. EXMEM_Halt: PC/IFID/IDEX WE=0; EXMEM Flush=1; MEMWB advances. Next state HALTING.
//   3. loaduse: PC/IFID WE=0; IDEX Flush=1.
//   4. IMem_Stall: PC/IFID WE=0; IDEX Flush=1. A branch in ID waits in ID until the miss clears.
//   5. ID_BranchTaken: PC WE=1 (target); IFID Flush=1.
//  DSTALL:
//   - Same outputs as RUN case 1 while DMem_Stall=1.
//   - When DMem_Stall=0: evaluate RUN priorities 2-5 in that cycle; next state RUN, or HALTING if EXMEM_Halt.
//  HALTING: all WE=0 except MEMWB WE=1 (the halt enters WB); next state HALTED unconditionally.
//  HALTED: all WE=0, all flushes 0, Halted=1; every input is ignored.
//  Simultaneous events:
//   - Priority order above is absolute; lower-priority causes are ignored that cycle and re-evaluated next cycle.
//  Reset mid-stall or mid-halt: state=RUN immediately (asynchronous); outputs 0 until release.
// CONFIGURATION
//  Macro PIPE_PERF_CNT_EN, when defined:
//   - Adds outputs StallCycles[CNT_W-1:0] and FlushCount[CNT_W-1:0].
//   - StallCycles increments each cycle PC_WriteEnable=0 while not HALTED.
//   - FlushCount increments each cycle any flush output is 1.
//   - Both saturate at all-ones, reset to 0, and freeze in HALTED.
//  Without the macro: ports and counters are absent; all other behaviour is identical.
// TESTING
//  1. Load-use: EX_MemRead=1, EX_WReg=3, ID_SrcReg1=3, ID_Uses1=1
//     -> PC/IFID WE=0, IDEX_Flush=1 for exactly 1 cycle.
//  2. EX_WReg=0 with a matching source -> no stall; all WE=1.
//  3. DMem_Stall high 4 cycles
//     -> 4 cycles of EXMEM WE=0 and MEMWB Flush=1, then normal flow; with PIPE_PERF_CNT_EN, StallCycles=4.
//  4. ID_BranchTaken with IMem_Stall=1 for 2 cycles
//     -> 2 cycles of PC WE=0 and IDEX Flush=1; then 1 cycle of PC WE=1 and IFID_Flush=1.
//  5. EXMEM_Halt with DMem_Stall=1
//     -> DSTALL until the stall drops, then HALTING for 1 cycle, then Halted=1 and all WE=0 indefinitely.
//  6. rst pulsed low while in HALTED
//     -> outputs 0 during reset; after release all WE=1, Halted=0, counters 0.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-controller signal bundle: pipeline status in, register enables/flushes out.
// With PIPE_PERF_CNT_EN defined it also carries the stall/flush performance counters.
interface pipeline_hazard_ctrl_if #(
  parameter int REG_W = 4
`ifdef PIPE_PERF_CNT_EN
  , parameter int CNT_W = 16
`endif
);
  logic [REG_W-1:0] ID_SrcReg1;
  logic [REG_W-1:0] ID_SrcReg2;
  logic             ID_Uses1;
  logic             ID_Uses2;
  logic             ID_BranchTaken;
  logic             EX_MemRead;
  logic [REG_W-1:0] EX_WReg;
  logic             EXMEM_Halt;
  logic             IMem_Stall;
  logic             DMem_Stall;

  logic             PC_WriteEnable;
  logic             IFID_WriteEnable;
  logic             IDEX_WriteEnable;
  logic             EXMEM_WriteEnable;
  logic             MEMWB_WriteEnable;
  logic             IFID_Flush;
  logic             IDEX_Flush;
  logic             EXMEM_Flush;
  logic             MEMWB_Flush;
  logic             Halted;
`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] StallCycles;
  logic [CNT_W-1:0] FlushCount;
`endif

  modport master (
    output ID_SrcReg1, ID_SrcReg2, ID_Uses1, ID_Uses2, ID_BranchTaken,
           EX_MemRead, EX_WReg, EXMEM_Halt, IMem_Stall, DMem_Stall,
    input  PC_WriteEnable, IFID_WriteEnable, IDEX_WriteEnable,
           EXMEM_WriteEnable, MEMWB_WriteEnable,
           IFID_Flush, IDEX_Flush, EXMEM_Flush, MEMWB_Flush, Halted
`ifdef PIPE_PERF_CNT_EN
    , input StallCycles, FlushCount
`endif
  );

  modport slave (
    input  ID_SrcReg1, ID_SrcReg2, ID_Uses1, ID_Uses2, ID_BranchTaken,
           EX_MemRead, EX_WReg, EXMEM_Halt, IMem_Stall, DMem_Stall,
    output PC_WriteEnable, IFID_WriteEnable, IDEX_WriteEnable,
           EXMEM_WriteEnable, MEMWB_WriteEnable,
           IFID_Flush, IDEX_Flush, EXMEM_Flush, MEMWB_Flush, Halted
`ifdef PIPE_PERF_CNT_EN
    , output StallCycles, FlushCount
`endif
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline; outputs are same-cycle combinational.
// Optional macro PIPE_PERF_CNT_EN adds saturating StallCycles/FlushCount counters.
module pipeline_hazard_ctrl #(
  parameter int REG_W = 4
`ifdef PIPE_PERF_CNT_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic                   clk,
  input  logic                   rst,
  pipeline_hazard_ctrl_if.slave  hz
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    DSTALL  = 2'd1,
    HALTING = 2'd2,
    HALTED  = 2'd3
  } state_t;

  localparam logic [REG_W-1:0] NO_REG = '0;

  state_t state_q, state_d;

  logic we_pc, we_ifid, we_idex, we_exmem, we_memwb;
  logic fl_ifid, fl_idex, fl_exmem, fl_memwb;
  logic halted;
  logic loaduse;

  // Register 0 is hard-wired, so a load targeting it can never create a hazard.
  assign loaduse = hz.EX_MemRead && (hz.EX_WReg != NO_REG) &&
                   ((hz.ID_Uses1 && (hz.ID_SrcReg1 == hz.EX_WReg)) ||
                    (hz.ID_Uses2 && (hz.ID_SrcReg2 == hz.EX_WReg)));

  always_comb begin
    we_pc    = 1'b1;
    we_ifid  = 1'b1;
    we_idex  = 1'b1;
    we_exmem = 1'b1;
    we_memwb = 1'b1;
    fl_ifid  = 1'b0;
    fl_idex  = 1'b0;
    fl_exmem = 1'b0;
    fl_memwb = 1'b0;
    halted   = 1'b0;
    state_d  = state_q;

    unique case (state_q)
      RUN, DSTALL: begin
        if (hz.DMem_Stall) begin
          // Freeze everything up to EX/MEM; WB receives a bubble each miss cycle.
          we_pc    = 1'b0;
          we_ifid  = 1'b0;
          we_idex  = 1'b0;
          we_exmem = 1'b0;
          fl_memwb = 1'b1;
          state_d  = DSTALL;
        end else if (hz.EXMEM_Halt) begin
          we_pc    = 1'b0;
          we_ifid  = 1'b0;
          we_idex  = 1'b0;
          fl_exmem = 1'b1;
          state_d  = HALTING;
        end else begin
          state_d = RUN;
          if (loaduse || hz.IMem_Stall) begin
            // A taken branch stays parked in ID until the fetch side is free.
            we_pc   = 1'b0;
            we_ifid = 1'b0;
            fl_idex = 1'b1;
          end else if (hz.ID_BranchTaken) begin
            fl_ifid = 1'b1;
          end
        end
      end
      HALTING: begin
        we_pc    = 1'b0;
        we_ifid  = 1'b0;
        we_idex  = 1'b0;
        we_exmem = 1'b0;
        state_d  = HALTED;
      end
      HALTED: begin
        we_pc    = 1'b0;
        we_ifid  = 1'b0;
        we_idex  = 1'b0;
        we_exmem = 1'b0;
        we_memwb = 1'b0;
        halted   = 1'b1;
      end
      default: state_d = RUN;
    endcase

    // Reset is asynchronous, so the outputs must drop in the same instant.
    if (!rst) begin
      we_pc    = 1'b0;
      we_ifid  = 1'b0;
      we_idex  = 1'b0;
      we_exmem = 1'b0;
      we_memwb = 1'b0;
      fl_ifid  = 1'b0;
      fl_idex  = 1'b0;
      fl_exmem = 1'b0;
      fl_memwb = 1'b0;
      halted   = 1'b0;
      state_d  = RUN;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  assign hz.PC_WriteEnable    = we_pc;
  assign hz.IFID_WriteEnable  = we_ifid;
  assign hz.IDEX_WriteEnable  = we_idex;
  assign hz.EXMEM_WriteEnable = we_exmem;
  assign hz.MEMWB_WriteEnable = we_memwb;
  assign hz.IFID_Flush        = fl_ifid;
  assign hz.IDEX_Flush        = fl_idex;
  assign hz.EXMEM_Flush       = fl_exmem;
  assign hz.MEMWB_Flush       = fl_memwb;
  assign hz.Halted            = halted;

`ifdef PIPE_PERF_CNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             any_flush;

  assign any_flush = fl_ifid | fl_idex | fl_exmem | fl_memwb;

  // Counters saturate rather than wrap and stop counting once halted.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (state_q != HALTED) begin
      if (!we_pc && (stall_cnt_q != CNT_MAX)) stall_cnt_d = stall_cnt_q + 1'b1;
      if (any_flush && (flush_cnt_q != CNT_MAX)) flush_cnt_d = flush_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign hz.StallCycles = stall_cnt_q;
  assign hz.FlushCount  = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: expected control vectors are queued as each
// step is driven and popped/compared at the following falling edge.
module tb_pipeline_hazard_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;

  pipeline_hazard_ctrl_if #(.REG_W(4)) hz ();

  pipeline_hazard_ctrl #(.REG_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz.slave)
  );

  always #5 clk = ~clk;

  // Vector: {PC,IFID,IDEX,EXMEM,MEMWB WE, IFID,IDEX,EXMEM,MEMWB Flush, Halted}
  localparam logic [9:0] V_RST  = 10'b00000_0000_0;
  localparam logic [9:0] V_NORM = 10'b11111_0000_0;
  localparam logic [9:0] V_LU   = 10'b00111_0100_0;
  localparam logic [9:0] V_BR   = 10'b11111_1000_0;
  localparam logic [9:0] V_DST  = 10'b00001_0001_0;
  localparam logic [9:0] V_HLT  = 10'b00011_0010_0;
  localparam logic [9:0] V_HING = 10'b00001_0000_0;
  localparam logic [9:0] V_HED  = 10'b00000_0000_1;

  logic [9:0] sb_q[$];
  string      tag_q[$];
  int         n_checks = 0;
  int         n_fails  = 0;
`ifdef PIPE_PERF_CNT_EN
  int         exp_stall = 0;
  int         exp_flush = 0;
`endif

  function automatic logic [9:0] observe();
    return {hz.PC_WriteEnable, hz.IFID_WriteEnable, hz.IDEX_WriteEnable,
            hz.EXMEM_WriteEnable, hz.MEMWB_WriteEnable,
            hz.IFID_Flush, hz.IDEX_Flush, hz.EXMEM_Flush, hz.MEMWB_Flush, hz.Halted};
  endfunction

  task automatic drive(input logic mr, input logic [3:0] wreg, input logic [3:0] s1,
                       input logic [3:0] s2, input logic u1, input logic u2,
                       input logic br, input logic halt, input logic im, input logic dm);
    hz.EX_MemRead     = mr;
    hz.EX_WReg        = wreg;
    hz.ID_SrcReg1     = s1;
    hz.ID_SrcReg2     = s2;
    hz.ID_Uses1       = u1;
    hz.ID_Uses2       = u2;
    hz.ID_BranchTaken = br;
    hz.EXMEM_Halt     = halt;
    hz.IMem_Stall     = im;
    hz.DMem_Stall     = dm;
  endtask

  // Queue the expectation, sample at the falling edge, then advance past the next rising edge.
  task automatic step(input string tag, input logic [9:0] exp);
    logic [9:0] e;
    logic [9:0] o;
    string      t;
    sb_q.push_back(exp);
    tag_q.push_back(tag);
    @(negedge clk);
    e = sb_q.pop_front();
    t = tag_q.pop_front();
    o = observe();
    n_checks++;
    assert (o === e) else begin
      n_fails++;
      $error("FAIL %s observed=%b expected=%b", t, o, e);
    end
`ifdef PIPE_PERF_CNT_EN
    if (!rst) begin
      exp_stall = 0;
      exp_flush = 0;
    end
    n_checks++;
    assert (hz.StallCycles === 16'(exp_stall)) else begin
      n_fails++;
      $error("FAIL %s_stallcnt observed=%0d expected=%0d", t, hz.StallCycles, exp_stall);
    end
    n_checks++;
    assert (hz.FlushCount === 16'(exp_flush)) else begin
      n_fails++;
      $error("FAIL %s_flushcnt observed=%0d expected=%0d", t, hz.FlushCount, exp_flush);
    end
    if (rst && !e[0]) begin
      if (!e[9] && exp_stall < 65535) exp_stall++;
      if ((|e[4:1]) && exp_flush < 65535) exp_flush++;
    end
`endif
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(1, 4'd3, 4'd3, 4'd0, 1, 0, 1, 1, 1, 1);
    #1;
    step("reset_busy_inputs", V_RST);
    step("reset_hold", V_RST);
    rst = 1'b1;
    drive(0, 4'd0, 4'd0, 4'd0, 0, 0, 0, 0, 0, 0);
    step("idle_run", V_NORM);

    // Load-use on src1, one cycle only
    drive(1, 4'd3, 4'd3, 4'd0, 1, 0, 0, 0, 0, 0);
    step("loaduse_src1", V_LU);
    drive(0, 4'd3, 4'd3, 4'd0, 1, 0, 0, 0, 0, 0);
    step("loaduse_cleared", V_NORM);
    drive(1, 4'd7, 4'd1, 4'd7, 1, 1, 0, 0, 0, 0);
    step("loaduse_src2", V_LU);
    drive(1, 4'd5, 4'd5, 4'd0, 0, 0, 0, 0, 0, 0);
    step("match_not_used", V_NORM);
    drive(1, 4'd0, 4'd0, 4'd0, 1, 1, 0, 0, 0, 0);
    step("wreg_zero", V_NORM);

    // Data miss for four cycles, a concurrent load-use is masked
    drive(0, 4'd0, 4'd0, 4'd0, 0, 0, 0, 0, 0, 1);
    step("dmem_c1", V_DST);
    step("dmem_c2", V_DST);
    drive(1, 4'd2, 4'd2, 4'd0, 1, 0, 1, 0, 1, 1);
    step("dmem_c3_masked", V_DST);
    drive(0, 4'd0, 4'd0, 4'd0, 0, 0, 0, 0, 0, 1);
    step("dmem_c4", V_DST);
    drive(0, 4'd0, 4'd0, 4'd0, 0, 0, 0, 0, 0, 0);
    step("dmem_done", V_NORM);

    // Branch waits behind an instruction miss, then redirects
    drive(0, 4'd0, 4'd0, 4'd0, 0, 0, 1, 0, 1, 0);
    step("br_imem_c1", V_LU);
    step("br_imem_c2", V_LU);
    drive(0, 4'd0, 4'd0, 4'd0, 0, 0, 1, 0, 0, 0);
    step("br_taken", V_BR);
    drive(0, 4'd0, 4'd0, 4'd0, 0, 0, 0, 0, 0, 0);
    step("br_after", V_NORM);

    // Leaving DSTALL evaluates lower priorities in the same cycle
    drive(0, 4'd0, 4'd0, 4'd0, 0, 0, 0, 0, 0, 1);
    step("dst_enter", V_DST);
    drive(1, 4'd4, 4'd0, 4'd4, 0, 1, 1, 0, 1, 0);
    step("dst_exit_loaduse", V_LU);
    drive(0, 4'd0, 4'd0, 4'd0, 0, 0, 1, 0, 0, 0);
    step("dst_back_run_br", V_BR);

    // Halt behind a data miss
    drive(0, 4'd0, 4'd0, 4'd0, 0, 0, 0, 1, 0, 1);
    step("halt_dmem_c1", V_DST);
    step("halt_dmem_c2", V_DST);
    drive(1, 4'd1, 4'd1, 4'd0, 1, 0, 1, 1, 1, 0);
    step("halt_issue", V_HLT);
    drive(0, 4'd0, 4'd0, 4'd0, 0, 0, 0, 0, 0, 1);
    step("halting", V_HING);
    step("halted_1", V_HED);
    drive(1, 4'd6, 4'd6, 4'd6, 1, 1, 1, 1, 1, 0);
    step("halted_2", V_HED);
    step("halted_3", V_HED);

    // Reset pulse while halted
    rst = 1'b0;
    step("rst_in_halted", V_RST);
    rst = 1'b1;
    drive(0, 4'd0, 4'd0, 4'd0, 0, 0, 0, 0, 0, 0);
    step("after_rst_run", V_NORM);

    // Halt straight from RUN, then reset in the middle of HALTING
    drive(0, 4'd0, 4'd0, 4'd0, 0, 0, 0, 1, 0, 0);
    step("halt_from_run", V_HLT);
    drive(0, 4'd0, 4'd0, 4'd0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    step("rst_in_halting", V_RST);
    rst = 1'b1;
    step("after_rst2", V_NORM);

    // Reset in the middle of a data stall
    drive(0, 4'd0, 4'd0, 4'd0, 0, 0, 0, 0, 0, 1);
    step("dst_before_rst", V_DST);
    rst = 1'b0;
    step("rst_in_dstall", V_RST);
    drive(0, 4'd0, 4'd0, 4'd0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    step("after_rst3", V_NORM);

    n_checks++;
    assert (sb_q.size() == 0) else begin
      n_fails++;
      $error("FAIL scoreboard_drain observed=%0d expected=0", sb_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
